// File: rtl/ntt_stage_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ntt_stage_sequencer: issue/drain control for an in-place DIF NTT |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ntt_stage_sequencer #(
  parameter int N        = 256,
  parameter int LOGN     = 8,
  parameter int STAGE_W  = 4,
  parameter int PIPE_LAT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                inverse,
  input  logic                stall,
  output logic                busy,
  output logic                done,
  output logic                inv_out,
  output logic                bf_valid,
  output logic [LOGN-1:0]     addr_a,
  output logic [LOGN-1:0]     addr_b,
  output logic [LOGN-2:0]     tw_idx,
  output logic [STAGE_W-1:0]  stage,
  output logic                wb_valid,
  output logic [LOGN-1:0]     wb_addr_a,
  output logic [LOGN-1:0]     wb_addr_b
);

  localparam int              DW       = $clog2(PIPE_LAT) + 1;
  localparam logic [LOGN-2:0] J_LAST   = '1;
  localparam logic [LOGN-2:0] K_ALL    = '1;
  localparam logic [LOGN-1:0] ONE      = LOGN'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [LOGN-2:0]      j_q, j_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic                 inv_q, inv_d;
  logic [LOGN-1:0]      addr_a_q, addr_a_d;
  logic [LOGN-1:0]      addr_b_q, addr_b_d;
  logic [LOGN-2:0]      tw_q, tw_d;

  logic [PIPE_LAT-1:0]  wb_v_q, wb_v_d;
  logic [LOGN-1:0]      wb_a_q [PIPE_LAT];
  logic [LOGN-1:0]      wb_a_d [PIPE_LAT];
  logic [LOGN-1:0]      wb_b_q [PIPE_LAT];
  logic [LOGN-1:0]      wb_b_d [PIPE_LAT];

  logic [LOGN-2:0]      k_mask;
  logic [LOGN-2:0]      k_w;
  logic [LOGN-2:0]      hi_w;
  logic [LOGN-1:0]      span_w;
  logic [LOGN-1:0]      addr_a_w;
  logic [LOGN-1:0]      addr_b_w;
  logic [LOGN-2:0]      tw_w;

  // k_mask = span-1; bits above it select the group, which is spread by one bit.
  always_comb begin
    k_mask   = K_ALL >> stage_q;
    k_w      = j_q & k_mask;
    hi_w     = j_q & ~k_mask;
    span_w   = {1'b0, k_mask} + ONE;
    addr_a_w = {hi_w, 1'b0} | {1'b0, k_w};
    addr_b_w = addr_a_w | span_w;
    tw_w     = k_w << stage_q;
  end

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    j_d      = j_q;
    drain_d  = drain_q;
    inv_d    = inv_q;
    bf_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          stage_d = '0;
          j_d     = '0;
          drain_d = '0;
          inv_d   = inverse;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (!stall) begin
          bf_valid = 1'b1;
          j_d      = j_q + 1'b1;
          if (j_q == J_LAST) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        busy    = 1'b1;
        drain_d = drain_q + 1'b1;
        if (drain_q == DW'(PIPE_LAT - 1)) begin
          drain_d = '0;
          if (stage_q == STAGE_W'(LOGN - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            stage_d = stage_q + 1'b1;
            j_d     = '0;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Idle cycles keep presenting the last issued beat.
  always_comb begin
    addr_a_d = bf_valid ? addr_a_w : addr_a_q;
    addr_b_d = bf_valid ? addr_b_w : addr_b_q;
    tw_d     = bf_valid ? tw_w     : tw_q;
  end

  always_comb begin
    wb_v_d[0] = bf_valid;
    wb_a_d[0] = addr_a_d;
    wb_b_d[0] = addr_b_d;
    for (int i = 1; i < PIPE_LAT; i++) begin
      wb_v_d[i] = wb_v_q[i-1];
      wb_a_d[i] = wb_a_q[i-1];
      wb_b_d[i] = wb_b_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      stage_q  <= '0;
      j_q      <= '0;
      drain_q  <= '0;
      inv_q    <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
      wb_v_q   <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        wb_a_q[i] <= '0;
        wb_b_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      j_q      <= j_d;
      drain_q  <= drain_d;
      inv_q    <= inv_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
      wb_v_q   <= wb_v_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        wb_a_q[i] <= wb_a_d[i];
        wb_b_q[i] <= wb_b_d[i];
      end
    end
  end

  assign addr_a    = addr_a_d;
  assign addr_b    = addr_b_d;
  assign tw_idx    = tw_d;
  assign stage     = stage_q;
  assign inv_out   = inv_q;
  assign wb_valid  = wb_v_q[PIPE_LAT-1];
  assign wb_addr_a = wb_a_q[PIPE_LAT-1];
  assign wb_addr_b = wb_b_q[PIPE_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ntt_stage_sequencer: directed checks for N=8 and N=256 builds |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_ntt_stage_sequencer;

  localparam int NC = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance
  logic       start = 1'b0, inverse = 1'b0, stall = 1'b0;
  logic       busy, done, inv_out, bf_valid, wb_valid;
  logic [2:0] addr_a, addr_b, wb_addr_a, wb_addr_b;
  logic [1:0] tw_idx;
  logic [3:0] stage;

  ntt_stage_sequencer #(.N(8), .LOGN(3), .STAGE_W(4), .PIPE_LAT(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse), .stall(stall),
    .busy(busy), .done(done), .inv_out(inv_out), .bf_valid(bf_valid),
    .addr_a(addr_a), .addr_b(addr_b), .tw_idx(tw_idx), .stage(stage),
    .wb_valid(wb_valid), .wb_addr_a(wb_addr_a), .wb_addr_b(wb_addr_b)
  );

  // N=256 instance, default parameters
  logic       start_b = 1'b0, inverse_b = 1'b0, stall_b = 1'b0;
  logic       busy_b, done_b, inv_b, bfv_b, wbv_b;
  logic [7:0] aa_b, ab_b, wba_b, wbb_b;
  logic [6:0] tw_b;
  logic [3:0] stg_b;

  ntt_stage_sequencer u_dut256 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .inverse(inverse_b), .stall(stall_b),
    .busy(busy_b), .done(done_b), .inv_out(inv_b), .bf_valid(bfv_b),
    .addr_a(aa_b), .addr_b(ab_b), .tw_idx(tw_b), .stage(stg_b),
    .wb_valid(wbv_b), .wb_addr_a(wba_b), .wb_addr_b(wbb_b)
  );

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
    logic [3:0] stg;
    int         cyc;     // issue cycle without stall
    int         cyc_st;  // issue cycle with stall at cycles 2-3
  } beat_t;

  beat_t tbl [12];

  logic       r_bfv [0:NC];
  logic       r_wbv [0:NC];
  logic       r_don [0:NC];
  logic       r_bsy [0:NC];
  logic       r_inv [0:NC];
  logic [2:0] r_aa  [0:NC];
  logic [2:0] r_ab  [0:NC];
  logic [2:0] r_wba [0:NC];
  logic [2:0] r_wbb [0:NC];
  logic [1:0] r_tw  [0:NC];
  logic [3:0] r_stg [0:NC];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sample(input int c);
    r_bfv[c] = bf_valid;  r_wbv[c] = wb_valid;  r_don[c] = done;
    r_bsy[c] = busy;      r_inv[c] = inv_out;   r_aa[c]  = addr_a;
    r_ab[c]  = addr_b;    r_wba[c] = wb_addr_a; r_wbb[c] = wb_addr_b;
    r_tw[c]  = tw_idx;    r_stg[c] = stage;
  endtask

  // Cycle 0 carries the accepted start; later inputs are set #1 after each edge.
  task automatic run(input int st_from, input int st_to, input int restart_at,
                     input int rst_at, input logic inv0);
    @(posedge clk);
    #1;
    start = 1'b1; inverse = inv0; stall = 1'b0;
    #1 sample(0);
    for (int c = 1; c <= NC; c++) begin
      @(posedge clk);
      #1;
      start   = (c == restart_at);
      inverse = 1'b0;
      stall   = (c >= st_from) && (c <= st_to);
      if (c == rst_at)     rst_n = 1'b0;
      if (c == rst_at + 1) rst_n = 1'b1;
      #1 sample(c);
    end
    start = 1'b0; stall = 1'b0;
  endtask

  task automatic check_run(input string tag, input bit stalled, input int done_cyc,
                           input logic exp_inv);
    int nb, nw, nd, nbusy, nlate, ninv;
    for (int i = 0; i < 12; i++) begin
      int cy;
      cy = stalled ? tbl[i].cyc_st : tbl[i].cyc;
      chk($sformatf("%s bf_valid beat%0d", tag, i), r_bfv[cy], 1);
      chk($sformatf("%s addr_a beat%0d", tag, i), r_aa[cy], tbl[i].a);
      chk($sformatf("%s addr_b beat%0d", tag, i), r_ab[cy], tbl[i].b);
      chk($sformatf("%s tw_idx beat%0d", tag, i), r_tw[cy], tbl[i].tw);
      chk($sformatf("%s stage beat%0d", tag, i), r_stg[cy], tbl[i].stg);
      chk($sformatf("%s wb_valid beat%0d", tag, i), r_wbv[cy+2], 1);
      chk($sformatf("%s wb_addr_a beat%0d", tag, i), r_wba[cy+2], tbl[i].a);
      chk($sformatf("%s wb_addr_b beat%0d", tag, i), r_wbb[cy+2], tbl[i].b);
    end
    nb = 0; nw = 0; nd = 0; nbusy = 0; nlate = 0; ninv = 0;
    for (int c = 1; c <= NC; c++) begin
      nb += int'(r_bfv[c]);
      nw += int'(r_wbv[c]);
      nd += int'(r_don[c]);
      if (c < done_cyc) nbusy += int'(r_bsy[c]);
      else              nlate += int'(r_bsy[c]) + int'(r_wbv[c]);
      if (r_inv[c] === exp_inv) ninv++;
    end
    chk({tag, " bf_valid count"}, nb, 12);
    chk({tag, " wb_valid count"}, nw, 12);
    chk({tag, " done count"}, nd, 1);
    chk({tag, " done cycle"}, r_don[done_cyc], 1);
    chk({tag, " busy during run"}, nbusy, done_cyc - 1);
    chk({tag, " busy/wb after done"}, nlate, 0);
    chk({tag, " inv_out cycles"}, ninv, NC);
  endtask

  task automatic run_big();
    int first, done_at, ndone, i7, n0;
    first = 0; done_at = 0; ndone = 0; i7 = 0; n0 = 0;
    @(posedge clk);
    #1 start_b = 1'b1;
    for (int c = 1; c <= 1100; c++) begin
      @(posedge clk);
      #1 start_b = 1'b0;
      #1;
      if (bfv_b && first == 0) first = c;
      if (done_b) begin ndone++; done_at = c; end
      if (bfv_b && stg_b == 4'd0) begin
        if (n0 == 127) begin
          chk("n256 s0 j127 addr_a", aa_b, 127);
          chk("n256 s0 j127 addr_b", ab_b, 255);
          chk("n256 s0 j127 tw_idx", tw_b, 127);
        end
        n0++;
      end
      if (bfv_b && stg_b == 4'd7) begin
        chk($sformatf("n256 s7 addr_a i%0d", i7), aa_b, 2 * i7);
        chk($sformatf("n256 s7 addr_b i%0d", i7), ab_b, 2 * i7 + 1);
        chk($sformatf("n256 s7 tw_idx i%0d", i7), tw_b, 0);
        i7++;
      end
    end
    chk("n256 first issue cycle", first, 1);
    chk("n256 done cycle", done_at, 1057);
    chk("n256 done count", ndone, 1);
    chk("n256 stage0 beats", n0, 128);
    chk("n256 stage7 beats", i7, 128);
  endtask

  initial begin
    tbl[0]  = '{3'd0, 3'd4, 2'd0, 4'd0,  1,  1};
    tbl[1]  = '{3'd1, 3'd5, 2'd1, 4'd0,  2,  4};
    tbl[2]  = '{3'd2, 3'd6, 2'd2, 4'd0,  3,  5};
    tbl[3]  = '{3'd3, 3'd7, 2'd3, 4'd0,  4,  6};
    tbl[4]  = '{3'd0, 3'd2, 2'd0, 4'd1,  7,  9};
    tbl[5]  = '{3'd1, 3'd3, 2'd2, 4'd1,  8, 10};
    tbl[6]  = '{3'd4, 3'd6, 2'd0, 4'd1,  9, 11};
    tbl[7]  = '{3'd5, 3'd7, 2'd2, 4'd1, 10, 12};
    tbl[8]  = '{3'd0, 3'd1, 2'd0, 4'd2, 13, 15};
    tbl[9]  = '{3'd2, 3'd3, 2'd0, 4'd2, 14, 16};
    tbl[10] = '{3'd4, 3'd5, 2'd0, 4'd2, 15, 17};
    tbl[11] = '{3'd6, 3'd7, 2'd0, 4'd2, 16, 18};

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset bf_valid", bf_valid, 0);
    chk("reset inv_out", inv_out, 0);
    chk("reset addr_a", addr_a, 0);
    chk("reset addr_b", addr_b, 0);
    chk("reset tw_idx", tw_idx, 0);
    chk("reset stage", stage, 0);
    chk("reset wb_valid", wb_valid, 0);
    chk("reset wb_addr", {wb_addr_a, wb_addr_b}, 0);
    rst_n = 1'b1;

    run(0, -1, -1, -1, 1'b0);
    check_run("plain", 1'b0, 19, 1'b0);
    chk("plain held addr_a in drain", r_aa[5], 3);
    chk("plain held addr_b in drain", r_ab[5], 7);

    run(2, 3, -1, -1, 1'b0);
    check_run("stall", 1'b1, 21, 1'b0);
    chk("stall bf_valid c2", r_bfv[2], 0);
    chk("stall bf_valid c3", r_bfv[3], 0);
    chk("stall held addr_a c3", r_aa[3], 0);

    run(0, -1, 5, -1, 1'b1);
    check_run("restart", 1'b0, 19, 1'b1);

    run(0, -1, -1, 8, 1'b0);
    begin
      int nd, nbv;
      nd = 0; nbv = 0;
      for (int c = 1; c <= NC; c++) nd += int'(r_don[c]);
      for (int c = 8; c <= NC; c++) nbv += int'(r_bfv[c]);
      chk("rst busy before", r_bsy[7], 1);
      chk("rst inv_out new start", r_inv[1], 0);
      chk("rst busy cleared", r_bsy[8], 0);
      chk("rst bf_valid cleared", r_bfv[8], 0);
      chk("rst wb_valid cleared", r_wbv[9], 0);
      chk("rst no issue after", nbv, 0);
      chk("rst no done", nd, 0);
    end

    run(0, -1, -1, -1, 1'b0);
    check_run("rerun", 1'b0, 19, 1'b0);

    run_big();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
